// File: rtl/uart_flow_receiver.sv
// Receive endpoint: buffers ciphertext, Caesar-decrypts the FIFO head,
// and asks the far end to pause/resume with XOFF/XON.
//
// Ports: clk, reset (sync, active-low); rx_data/rx_valid in;
// out_data/out_valid/out_ready consumer handshake; tx_data/tx_start
// to the transmitter, tx_busy/tx_done back; xoff_active, fill_level,
// overflow status.
module uart_flow_receiver #(
  parameter int DEPTH     = 16,
  parameter int HIGH_MARK = 12,
  parameter int LOW_MARK  = 4,
  parameter int SHIFT     = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic                       xoff_active,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] XON  = 8'h11;
  localparam logic [7:0] XOFF = 8'h13;
  localparam logic [4:0] KEY  = 5'(SHIFT);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] HI   = CW'(HIGH_MARK);
  localparam logic [CW-1:0] LO   = CW'(LOW_MARK);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          is_ctrl;
  logic          push_req;
  logic          full;
  logic          pop;
  logic          push;

  state_t        state;
  state_t        state_d;
  logic [7:0]    tx_data_d;
  logic          xoff_d;
  logic          start_d;
  logic          hi_hit;
  logic          lo_hit;

  always_comb begin
    is_ctrl  = (rx_data == XON) || (rx_data == XOFF);
    push_req = rx_valid && !is_ctrl;
    full     = (count == FULL);
    pop      = out_valid && out_ready;
    // a pop frees a slot at the same edge, so full can still accept
    push     = push_req && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  function automatic logic [7:0] caesar(input logic [7:0] b);
    logic       letter;
    logic [7:0] base;
    logic [4:0] off;
    logic [4:0] res;
    logic       borrow;
    letter = ((b >= 8'h41) && (b <= 8'h5A)) ||
             ((b >= 8'h61) && (b <= 8'h7A));
    base   = (b >= 8'h61) ? 8'h61 : 8'h41;
    off    = 5'(b - base);
    {borrow, res} = {1'b0, off} - {1'b0, KEY};
    if (borrow) begin
      res = res + 5'd26;
    end
    return letter ? (base + {3'b000, res}) : b;
  endfunction

  assign out_data   = caesar(mem[rd_ptr]);
  assign out_valid  = (count != '0);
  assign fill_level = count;

  assign hi_hit = !xoff_active && (count >= HI);
  assign lo_hit = xoff_active && (count <= LO);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      tx_data     <= 8'h00;
      xoff_active <= 1'b0;
      tx_start    <= 1'b0;
    end else begin
      state       <= state_d;
      tx_data     <= tx_data_d;
      xoff_active <= xoff_d;
      tx_start    <= start_d;
    end
  end

  // REQ leaves only once the registered pulse has been issued
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (hi_hit || lo_hit) state_d = REQ;
      REQ:     if (tx_start) state_d = WAIT;
      WAIT:    if (tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_data_d = tx_data;
    xoff_d    = xoff_active;
    if (state == IDLE) begin
      unique case (1'b1)
        hi_hit: begin
          tx_data_d = XOFF;
          xoff_d    = 1'b1;
        end
        lo_hit: begin
          tx_data_d = XON;
          xoff_d    = 1'b0;
        end
        default: ;
      endcase
    end
    start_d = (state_d == REQ) && !tx_busy;
  end

endmodule

// File: tb/tb_uart_flow_receiver.sv
// Scoreboard bench for uart_flow_receiver: decryption, FIFO order,
// overflow, full push/pop, control filtering and XOFF/XON signalling.
module tb_uart_flow_receiver;

  localparam int DEPTH = 16;
  localparam int HIGH  = 12;
  localparam int LOW   = 4;
  localparam int SHIFT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       tx_done = 1'b0;
  logic       xoff_active;
  logic [4:0] fill_level;
  logic       overflow;

  uart_flow_receiver #(
    .DEPTH(DEPTH),
    .HIGH_MARK(HIGH),
    .LOW_MARK(LOW),
    .SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .xoff_active(xoff_active),
    .fill_level(fill_level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         cnt_m = 0;
  bit         ovf_m = 1'b0;
  int         tx_cnt = 0;
  logic [7:0] last_tx = 8'h00;
  int         t0;

  always @(posedge clk) begin
    if (reset && tx_start) begin
      tx_cnt  <= tx_cnt + 1;
      last_tx <= tx_data;
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mdec(logic [7:0] b);
    int v;
    v = int'(b);
    if (v >= 65 && v <= 90)
      return 8'(((v - 65 - SHIFT + 26) % 26) + 65);
    if (v >= 97 && v <= 122)
      return 8'(((v - 97 - SHIFT + 26) % 26) + 97);
    return b;
  endfunction

  // called at a negedge; applies inputs for the next posedge
  task automatic cyc(bit v, logic [7:0] d, bit rdy);
    bit pop;
    bit ctrl;
    rx_valid  = v;
    rx_data   = d;
    out_ready = rdy;
    pop  = rdy && (exp_q.size() > 0);
    ctrl = (d == 8'h11) || (d == 8'h13);
    if (pop) begin
      chk("head", out_data, exp_q[0]);
      void'(exp_q.pop_front());
      cnt_m--;
    end
    if (v && !ctrl) begin
      if (cnt_m < DEPTH) begin
        exp_q.push_back(mdec(d));
        cnt_m++;
      end else begin
        ovf_m = 1'b1;
      end
    end
    @(negedge clk);
    tx_done  = 1'b0;
    rx_valid = 1'b0;
    chk("fill", fill_level, cnt_m);
    chk("ovf", overflow, ovf_m);
    chk("valid", out_valid, cnt_m != 0);
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    tx_busy  = 1'b0;
    tx_done  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_xoff", xoff_active, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_txd", tx_data, 8'h00);
    rx_valid = 1'b0;
    reset    = 1'b1;
    exp_q.delete();
    cnt_m = 0;
    ovf_m = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    cyc(1, 8'h44, 1);
    chk("dec_D", out_data, 8'h41);
    cyc(1, 8'h63, 1);
    cyc(1, 8'h35, 1);
    cyc(1, 8'hC8, 1);
    cyc(1, 8'h41, 1);
    cyc(1, 8'h7A, 1);
    cyc(1, 8'h40, 1);
    cyc(0, 8'h00, 1);
    chk("dec_empty", out_valid, 0);

    do_reset();
    for (int i = 0; i < 12; i++) cyc(1, 8'h61 + 8'(i), 0);
    chk("xoff_early", tx_start, 0);
    cyc(0, 8'h00, 0);
    chk("xoff_start", tx_start, 1);
    chk("xoff_data", tx_data, 8'h13);
    chk("xoff_act", xoff_active, 1);
    cyc(0, 8'h00, 0);
    chk("xoff_pulse1", tx_start, 0);
    tx_done = 1'b1;
    cyc(0, 8'h00, 0);
    t0 = tx_cnt;
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1);
    chk("xon_fill", fill_level, 4);
    repeat (3) cyc(0, 8'h00, 0);
    chk("xon_cnt", tx_cnt, t0 + 1);
    chk("xon_data", last_tx, 8'h11);
    chk("xon_act", xoff_active, 0);
    tx_done = 1'b1;
    cyc(0, 8'h00, 0);

    do_reset();
    for (int i = 0; i < 17; i++) cyc(1, 8'h40 + 8'(i), 0);
    chk("ovf_fill", fill_level, 16);
    chk("ovf_flag", overflow, 1);
    tx_done = 1'b1;
    cyc(0, 8'h00, 0);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1);
    chk("ovf_empty", out_valid, 0);
    chk("ovf_sticky", overflow, 1);

    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 8'h50 + 8'(i), 0);
    cyc(1, 8'h7A, 1);
    chk("pp_fill", fill_level, 16);
    chk("pp_ovf", overflow, 0);
    tx_done = 1'b1;
    cyc(0, 8'h00, 0);
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1);
    chk("pp_empty", exp_q.size(), 0);

    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 8'h30 + 8'(i), 0);
    cyc(1, 8'h11, 0);
    cyc(1, 8'h13, 0);
    chk("ctrl_fill", fill_level, 3);

    do_reset();
    tx_busy = 1'b1;
    t0 = tx_cnt;
    for (int i = 0; i < 12; i++) cyc(1, 8'h20 + 8'(i), 0);
    repeat (5) cyc(0, 8'h00, 0);
    chk("busy_hold", tx_cnt, t0);
    chk("busy_start", tx_start, 0);
    tx_busy = 1'b0;
    repeat (3) cyc(0, 8'h00, 0);
    chk("busy_cnt", tx_cnt, t0 + 1);
    chk("busy_data", last_tx, 8'h13);
    repeat (3) cyc(0, 8'h00, 0);
    chk("busy_single", tx_cnt, t0 + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
